// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and counter operation codes
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // One operation is chosen per edge; clr outranks load, which outranks inc/dec.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } bcd_op_t;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - combinational single BCD digit increment/decrement with carry/borrow
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t d_i,
    input  logic       step_i,
    input  logic       dir_i,
    output bcd_digit_t q_o,
    output logic       co_o
);

    // Values at or above 9 roll to 0 going up, so an illegal input never propagates.
    always_comb begin
        q_o  = d_i;
        co_o = 1'b0;
        if (step_i) begin
            if (!dir_i) begin
                if (d_i >= BCD_MAX) begin
                    q_o  = 4'd0;
                    co_o = 1'b1;
                end else begin
                    q_o = d_i + 4'd1;
                end
            end else begin
                if (d_i == 4'd0) begin
                    q_o  = BCD_MAX;
                    co_o = 1'b1;
                end else if (!bcd_valid(d_i)) begin
                    q_o = BCD_MAX;
                end else begin
                    q_o = d_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - registered multi-digit BCD up/down counter with wrap/saturate and event pulses
module bcd_score_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    ovf_o,
    output logic                    unf_o,
    output logic                    load_err_o,
    output logic                    is_zero_o,
    output logic                    is_max_o
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]        count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                load_err_q, load_err_d;

    bcd_op_t             op;
    logic                dir;
    logic [NUM_DIGITS:0] step;
    logic [W-1:0]        stepped;
    logic                boundary;
    logic                load_ok;

    always_comb begin
        op = OP_HOLD;
        if (clr_i) begin
            op = OP_CLR;
        end else if (load_i) begin
            op = OP_LOAD;
        end else if (inc_i && !dec_i) begin
            op = OP_INC;
        end else if (dec_i && !inc_i) begin
            op = OP_DEC;
        end
    end

    assign dir     = (op == OP_DEC);
    assign step[0] = 1'b1;

    // Digit i+1 moves only when every lower digit carried/borrowed out.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .d_i    (count_q[4*g +: 4]),
            .step_i (step[g]),
            .dir_i  (dir),
            .q_o    (stepped[4*g +: 4]),
            .co_o   (step[g+1])
        );
    end

    // Carry out of the top digit means the count was at all-9s (up) or zero (down).
    assign boundary = step[NUM_DIGITS];

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bcd_valid(load_val_i[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        load_err_d = 1'b0;
        unique case (op)
            OP_CLR: begin
                count_d = '0;
            end
            OP_LOAD: begin
                if (load_ok) begin
                    count_d = load_val_i;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            OP_INC: begin
                ovf_d = boundary;
                if (!boundary || WRAP) begin
                    count_d = stepped;
                end
            end
            OP_DEC: begin
                unf_d = boundary;
                if (!boundary || WRAP) begin
                    count_d = stepped;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count_o    = count_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign load_err_o = load_err_q;
    assign is_zero_o  = (count_q == '0);
    assign is_max_o   = (count_q == {NUM_DIGITS{BCD_MAX}});

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                assert (bcd_valid(count_q[4*i +: 4]))
                else $error("bcd_score_counter: non-BCD digit %0d in count", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb/tb_bcd_score_counter.sv - randomized and directed checks of bcd_score_counter against a decimal model
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [15:0] load_val = '0;

    logic [7:0]  c2w, c2s;
    logic [15:0] c4w;
    logic        o2w, u2w, l2w, z2w, m2w;
    logic        o2s, u2s, l2s, z2s, m2s;
    logic        o4w, u4w, l4w, z4w, m4w;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int mv[3];
    bit mo[3], mu[3], ml[3];
    int ndig[3] = '{2, 2, 4};
    bit wrp[3]  = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b1)) u_2w (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val[7:0]),
        .inc_i(inc), .dec_i(dec), .count_o(c2w), .ovf_o(o2w), .unf_o(u2w),
        .load_err_o(l2w), .is_zero_o(z2w), .is_max_o(m2w));

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b0)) u_2s (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val[7:0]),
        .inc_i(inc), .dec_i(dec), .count_o(c2s), .ovf_o(o2s), .unf_o(u2s),
        .load_err_o(l2s), .is_zero_o(z2s), .is_max_o(m2s));

    bcd_score_counter #(.NUM_DIGITS(4), .WRAP(1'b1)) u_4w (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .inc_i(inc), .dec_i(dec), .count_o(c4w), .ovf_o(o4w), .unf_o(u4w),
        .load_err_o(l4w), .is_zero_o(z4w), .is_max_o(m4w));

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int max_of(input int n);
        int m;
        m = 1;
        for (int i = 0; i < n; i++) m = m * 10;
        return m - 1;
    endfunction

    // Score counter as plain integer arithmetic on the decimal value.
    task automatic model_step(input int k);
        int  lv;
        bit  ok;
        int  mx;
        mx = max_of(ndig[k]);
        mo[k] = 1'b0; mu[k] = 1'b0; ml[k] = 1'b0;
        lv = 0;
        ok = 1'b1;
        for (int i = ndig[k] - 1; i >= 0; i--) begin
            if (load_val[4*i +: 4] > 4'd9) ok = 1'b0;
            lv = lv * 10 + int'(load_val[4*i +: 4]);
        end
        if (clr) begin
            mv[k] = 0;
        end else if (load) begin
            if (ok) mv[k] = lv;
            else ml[k] = 1'b1;
        end else if (inc && !dec) begin
            if (mv[k] == mx) begin
                mo[k] = 1'b1;
                if (wrp[k]) mv[k] = 0;
            end else begin
                mv[k] = mv[k] + 1;
            end
        end else if (dec && !inc) begin
            if (mv[k] == 0) begin
                mu[k] = 1'b1;
                if (wrp[k]) mv[k] = mx;
            end else begin
                mv[k] = mv[k] - 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] = 0; mo[k] = 1'b0; mu[k] = 1'b0; ml[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [15:0] c, input logic o, input logic u,
                       input logic l, input logic z, input logic m);
        logic [31:0] eb;
        eb = to_bcd(mv[k]);
        if (ndig[k] == 2) eb = eb & 32'h00ff;
        else eb = eb & 32'hffff;
        chk($sformatf("u%0d.count", k), {16'h0, c}, eb);
        chk($sformatf("u%0d.ovf", k), {31'h0, o}, {31'h0, mo[k]});
        chk($sformatf("u%0d.unf", k), {31'h0, u}, {31'h0, mu[k]});
        chk($sformatf("u%0d.load_err", k), {31'h0, l}, {31'h0, ml[k]});
        chk($sformatf("u%0d.is_zero", k), {31'h0, z}, {31'h0, mv[k] == 0});
        chk($sformatf("u%0d.is_max", k), {31'h0, m}, {31'h0, mv[k] == max_of(ndig[k])});
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp(0, {8'h0, c2w}, o2w, u2w, l2w, z2w, m2w);
            cmp(1, {8'h0, c2s}, o2s, u2s, l2s, z2s, m2s);
            cmp(2, c4w, o4w, u4w, l4w, z4w, m4w);
        end
    end

    task automatic cyc(input bit c, input bit l, input logic [15:0] v, input bit i, input bit d);
        clr = c; load = l; load_val = v; inc = i; dec = d;
        @(posedge clk);
        #1;
        clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    function automatic logic [15:0] rand_load();
        logic [15:0] v;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) v = 16'h0000;
        else if (sel == 1) v = 16'h9999;
        else if (sel == 2) v = 16'h0099;
        else begin
            for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            if (sel == 3) v[4*$urandom_range(0, 1) +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        int ovf_seen;
        @(posedge clk);
        #1;
        chk("reset.count2w", {24'h0, c2w}, 32'h0);
        chk("reset.count4w", {16'h0, c4w}, 32'h0);
        chk("reset.flags2w", {29'h0, o2w, u2w, l2w}, 32'h0);
        chk("reset.is_zero", {31'h0, z2w}, 32'h1);
        chk("reset.is_max", {31'h0, m2w}, 32'h0);
        rst_n = 1'b1;
        check_en = 1'b1;

        ovf_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("t1.count k=%0d", k), {24'h0, c2w}, to_bcd(k % 100) & 32'hff);
            chk($sformatf("t1.ovf k=%0d", k), {31'h0, o2w}, {31'h0, k == 100});
            if (o2w) ovf_seen++;
        end
        chk("t1.ovf_pulses", ovf_seen, 1);
        chk("t1.sat_count", {24'h0, c2s}, 32'h99);
        chk("t1.count4w", {16'h0, c4w}, 32'h0100);

        cyc(1'b0, 1'b1, 16'h0098, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("t2.sat_count k=%0d", k), {24'h0, c2s}, 32'h99);
            chk($sformatf("t2.sat_ovf k=%0d", k), {31'h0, o2s}, {31'h0, k >= 2});
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t2.dec_count", {24'h0, c2s}, 32'h98);
        chk("t2.dec_unf", {31'h0, u2s}, 32'h0);

        cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3.borrow", {24'h0, c2w}, 32'h09);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3.wrap_count", {24'h0, c2w}, 32'h99);
        chk("t3.wrap_unf", {31'h0, u2w}, 32'h1);
        chk("t3.sat_zero", {24'h0, c2s}, 32'h00);
        chk("t3.sat_unf", {31'h0, u2s}, 32'h1);
        chk("t3.wrap4", {16'h0, c4w}, 32'h9999);

        cyc(1'b0, 1'b1, 16'h003A, 1'b0, 1'b0);
        chk("t4.bad_load_count", {24'h0, c2w}, 32'h99);
        chk("t4.load_err", {31'h0, l2w}, 32'h1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("t4.load_err_clear", {31'h0, l2w}, 32'h0);
        cyc(1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
        chk("t4.load_beats_inc", {24'h0, c2w}, 32'h42);

        cyc(1'b0, 1'b1, 16'h0099, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h0055, 1'b1, 1'b0);
        chk("t5.clr_count", {24'h0, c2w}, 32'h00);
        chk("t5.clr_flags", {29'h0, o2w, u2w, l2w}, 32'h0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("t5.incdec_hold", {24'h0, c2w}, 32'h00);
        chk("t5.incdec_flags", {29'h0, o2w, u2w, l2w}, 32'h0);

        cyc(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6.carry4", {16'h0, c4w}, 32'h1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async_rst2w", {24'h0, c2w}, 32'h0);
        chk("t6.async_rst4w", {16'h0, c4w}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            clr = (r < 4);
            load = (r >= 4 && r < 18);
            load_val = rand_load();
            inc = ($urandom_range(0, 9) < 6);
            dec = ($urandom_range(0, 9) < 4);
            if (n == 200) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("rand.async_rst", {16'h0, c4w}, 32'h0);
            end
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
